uart_rx_sampler: RTL and testbench
==================================

Name: uart_rx_sampler

Overview:
- Front end of the APB UART receiver. Synchronizes the asynchronous RXD pin and detects and validates the start bit using the 16x baud tick.
- Emits one majority-voted bit strobe per bit period.
- BIT_STB drives the ENABLE input of the downstream slib_counter bit counter. The downstream frame logic returns FRAME_END when the frame is complete.

Parameters:
- OVERSAMPLE, 16, baud ticks per bit; even, >= 4. Let M = OVERSAMPLE/2.
- SYNC_STAGES, 2, flip-flop stages in the RXD synchronizer; >= 2.

Ports:
- CLK  input  1  system clock; sole clock domain.
- RST  input  1  synchronous, active-high reset.
- RXD  input  1  asynchronous serial input, idle high.
- BAUDTICK  input  1  single-cycle enable at OVERSAMPLE x baud rate.
- ENABLE  input  1  receiver enable; low forces IDLE.
- FRAME_END  input  1  single-cycle pulse from downstream; frame complete.
- RXD_S  output  1  synchronized (optionally filtered) RXD.
- BUSY  output  1  high in START or DATA.
- START_DET  output  1  single-cycle pulse; valid start bit confirmed.
- FALSE_START  output  1  single-cycle pulse; start bit rejected.
- BIT_STB  output  1  single-cycle pulse; one data/stop bit sampled.
- BIT_VAL  output  1  voted bit value; valid while BIT_STB is high, held otherwise.

Behaviour:
- Reset (synchronous, RST=1 at a CLK edge): state IDLE, ARMED=0, phase P=0, vote shift register 0.
  - Synchronizer flops reset to 1, so RXD_S=1.
  - BUSY, START_DET, FALSE_START, BIT_STB and BIT_VAL are all 0.
- Synchronizer: RXD passes through SYNC_STAGES flops to produce RXD_S. Latency is SYNC_STAGES cycles.
- All sequencing below advances only in cycles where BAUDTICK=1 (sequencing cycles), unless stated otherwise.
- State IDLE:
  - Any tick with RXD_S=1 sets ARMED=1.
  - A tick with ARMED=1 and RXD_S=0 moves to START with P=1 (the detection tick counts as phase 0) and clears ARMED.
  - If ARMED=0, a low line is ignored. This covers break and reset while the line is low.
- States START and DATA:
  - On each tick, P <= (P+1) mod OVERSAMPLE. P is compared before increment.
  - RXD_S is captured into the 3-bit vote register at P = M-1, M and M+1.
  - At the tick with P = M+1, the majority of the three samples is evaluated and registered. Resulting outputs are high in the following cycle only:
    - START, vote=0: START_DET=1, go to DATA.
    - START, vote=1: FALSE_START=1, go to IDLE.
    - DATA: BIT_STB=1, BIT_VAL=vote, stay in DATA.
  - The phase counter wraps freely, so each bit centre falls OVERSAMPLE ticks after the previous one.
- FRAME_END in DATA: go to IDLE on the next edge, with P=0.
  - A strobe registered in the same cycle is still issued.
  - FRAME_END in IDLE or START is ignored.
- ENABLE=0: go to IDLE on the next edge and clear P and ARMED. Pending strobes are suppressed. Synchronizer flops keep running.
- BAUDTICK coincident with FRAME_END or ENABLE=0: the exit takes priority and no phase advance occurs.
- Phase counter width is $clog2(OVERSAMPLE). Arithmetic is unsigned and wraps modulo OVERSAMPLE.

Optional Feature:
- Macro: UART_RX_GLITCH_FILTER_EN.
- Defined: RXD_S is the registered majority of the last three synchronized samples, updated on every CLK cycle.
  - Adds 1 cycle of latency.
  - Rejects single-cycle glitches.
  - The filter flops reset to 1.
- Undefined: RXD_S is the last synchronizer stage directly.
- All other behaviour is identical in both cases.

Decomposition:
- uart_pkg holds:
  - the state enum rx_state_t (IDLE, START, DATA);
  - localparam functions for the vote positions M-1, M and M+1;
  - the maj3 function.
- Sub-module slib_input_sync: SYNC_STAGES synchronizer plus the optional glitch filter; input RXD, output RXD_S. It is reusable for CTS/DSR/DCD/RI.

Test Plan (OVERSAMPLE=16, BAUDTICK every 4 CLK, ENABLE=1 unless stated):
- Reset with RXD=1 -> all outputs 0, RXD_S=1. After 1 tick high, ARMED=1 and BUSY stays 0.
- RXD falls and stays low for 16 ticks -> BUSY=1 after the detection tick. START_DET pulses for 1 cycle after the 10th tick (P=9). No FALSE_START.
- RXD low for 3 ticks, then high -> FALSE_START pulses once, START_DET is never asserted, BUSY=0 after the pulse.
- Frame: start bit, 0x55 LSB first, stop bit 1, FRAME_END after the 9th BIT_STB -> 9 strobes 16 ticks apart, BIT_VAL = 1,0,1,0,1,0,1,0,1, then BUSY=0.
- Inside a '1' bit, RXD forced low for the single tick at P=8 -> BIT_VAL=1 (majority).
- Two cases:
  - RXD held low after FRAME_END (break) -> no START until RXD is high for at least one tick.
  - ENABLE dropped mid-DATA -> BUSY=0 next cycle and no further BIT_STB.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the APB UART receive front end.
//   rx_state_t    : receive sequencer state (IDLE, START, DATA)
//   vote_pos_lo/mid/hi : phase positions of the three bit-centre samples
//   maj3          : 2-of-3 majority of a 3-bit sample vector
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2
    } rx_state_t;

    // First vote position, one tick before the bit centre.
    function automatic int vote_pos_lo(input int oversample);
        return (oversample / 32'sd2) - 32'sd1;
    endfunction

    // Bit centre.
    function automatic int vote_pos_mid(input int oversample);
        return oversample / 32'sd2;
    endfunction

    // Last vote position; the majority is evaluated on this tick.
    function automatic int vote_pos_hi(input int oversample);
        return (oversample / 32'sd2) + 32'sd1;
    endfunction

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/slib_input_sync.sv
// -----------------------------------------------------------------------------
// slib_input_sync
// Brings an asynchronous level input into the CLK domain. Reusable for RXD and
// the modem status lines (CTS/DSR/DCD/RI).
//
// Build option: UART_RX_GLITCH_FILTER_EN
//   defined   : RXD_S is the registered majority of the last three synchronized
//               samples (one extra cycle of latency, single-cycle glitches
//               rejected).
//   undefined : RXD_S is the last synchronizer stage.
//
// Ports:
//   CLK   in  system clock
//   RST   in  synchronous active-high reset (all flops reset to 1, line idle)
//   RXD   in  asynchronous input
//   RXD_S out synchronized (optionally filtered) input
// -----------------------------------------------------------------------------
module slib_input_sync
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic RXD,
    output logic RXD_S
);

    logic [SYNC_STAGES-1:0] sync_r;

    // Synchronizer shift chain; resets to the idle-high line level.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], RXD};
        end
    end

`ifdef UART_RX_GLITCH_FILTER_EN
    logic [1:0] hist_r;
    logic       filt_r;

    // Keep two older synchronized samples and register the 2-of-3 majority.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hist_r <= 2'b11;
            filt_r <= 1'b1;
        end else begin
            hist_r <= {hist_r[0], sync_r[SYNC_STAGES-1]};
            filt_r <= maj3({sync_r[SYNC_STAGES-1], hist_r});
        end
    end

    assign RXD_S = filt_r;
`else
    assign RXD_S = sync_r[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Receive front end of the APB UART: synchronizes RXD, validates the start bit
// and emits one majority-voted strobe per data/stop bit, all paced by the
// OVERSAMPLE x baud tick.
//
// Build option: UART_RX_GLITCH_FILTER_EN (see slib_input_sync).
//
// Parameters:
//   OVERSAMPLE  baud ticks per bit (even, >= 4)
//   SYNC_STAGES RXD synchronizer depth (>= 2)
//
// Ports:
//   CLK         in  system clock
//   RST         in  synchronous active-high reset
//   RXD         in  asynchronous serial input, idle high
//   BAUDTICK    in  single-cycle enable at OVERSAMPLE x baud
//   ENABLE      in  receiver enable; low forces IDLE
//   FRAME_END   in  pulse from the frame logic, frame complete
//   RXD_S       out synchronized RXD
//   BUSY        out high in START or DATA
//   START_DET   out pulse, start bit confirmed
//   FALSE_START out pulse, start bit rejected
//   BIT_STB     out pulse, one data/stop bit sampled
//   BIT_VAL     out voted bit value, held between strobes
// -----------------------------------------------------------------------------
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic RXD,
    input  logic BAUDTICK,
    input  logic ENABLE,
    input  logic FRAME_END,
    output logic RXD_S,
    output logic BUSY,
    output logic START_DET,
    output logic FALSE_START,
    output logic BIT_STB,
    output logic BIT_VAL
);

    localparam int            PW      = $clog2(OVERSAMPLE);
    localparam logic [PW-1:0] PH_ZERO = PW'(0);
    localparam logic [PW-1:0] PH_ONE  = PW'(1);
    localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 32'sd1);
    localparam logic [PW-1:0] PH_LO   = PW'(vote_pos_lo(OVERSAMPLE));
    localparam logic [PW-1:0] PH_MID  = PW'(vote_pos_mid(OVERSAMPLE));
    localparam logic [PW-1:0] PH_HI   = PW'(vote_pos_hi(OVERSAMPLE));

    rx_state_t     state_r;
    logic          armed_r;
    logic [PW-1:0] phase_r;
    // The first two samples of the vote are stored; the third is the live
    // sample on the evaluation tick, so the stored history is two bits wide.
    logic [1:0]    vote_r;
    logic          busy_r;
    logic          start_det_r;
    logic          false_start_r;
    logic          bit_stb_r;
    logic          bit_val_r;

    logic          rxd_s_s;
    logic [2:0]    vote_next_s;
    logic          vote_bit_s;
    logic [PW-1:0] phase_next_s;

    slib_input_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rxd_sync (
        .CLK   (CLK),
        .RST   (RST),
        .RXD   (RXD),
        .RXD_S (rxd_s_s)
    );

    assign vote_next_s  = {vote_r, rxd_s_s};
    assign vote_bit_s   = maj3(vote_next_s);
    // Explicit wrap so non-power-of-two OVERSAMPLE values still count modulo.
    assign phase_next_s = (phase_r == PH_LAST) ? PH_ZERO : (phase_r + PH_ONE);

    // Receive sequencer: arming, start validation, bit-centre voting and exits.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r       <= IDLE;
            armed_r       <= 1'b0;
            phase_r       <= PH_ZERO;
            vote_r        <= 2'b00;
            busy_r        <= 1'b0;
            start_det_r   <= 1'b0;
            false_start_r <= 1'b0;
            bit_stb_r     <= 1'b0;
            bit_val_r     <= 1'b0;
        end else begin
            start_det_r   <= 1'b0;
            false_start_r <= 1'b0;
            bit_stb_r     <= 1'b0;
            if (!ENABLE) begin
                // Disabled: drop everything, any bit being evaluated is lost.
                state_r <= IDLE;
                phase_r <= PH_ZERO;
                armed_r <= 1'b0;
                busy_r  <= 1'b0;
            end else if (FRAME_END && (state_r == DATA)) begin
                state_r <= IDLE;
                phase_r <= PH_ZERO;
                busy_r  <= 1'b0;
                // A bit centre evaluated on this very tick still gets its strobe.
                if (BAUDTICK && (phase_r == PH_HI)) begin
                    bit_stb_r <= 1'b1;
                    bit_val_r <= vote_bit_s;
                end
            end else if (BAUDTICK) begin
                case (state_r)
                    IDLE: begin
                        // Only a high-to-low transition seen on ticks starts a
                        // frame; a line that was already low (break) is ignored.
                        if (rxd_s_s) begin
                            armed_r <= 1'b1;
                        end else if (armed_r) begin
                            state_r <= START;
                            phase_r <= PH_ONE;
                            armed_r <= 1'b0;
                            busy_r  <= 1'b1;
                        end
                    end
                    START, DATA: begin
                        phase_r <= phase_next_s;
                        if ((phase_r == PH_LO) || (phase_r == PH_MID)) begin
                            vote_r <= vote_next_s[1:0];
                        end
                        if (phase_r == PH_HI) begin
                            if (state_r == START) begin
                                if (vote_bit_s) begin
                                    false_start_r <= 1'b1;
                                    state_r       <= IDLE;
                                    phase_r       <= PH_ZERO;
                                    busy_r        <= 1'b0;
                                end else begin
                                    start_det_r <= 1'b1;
                                    state_r     <= DATA;
                                end
                            end else begin
                                bit_stb_r <= 1'b1;
                                bit_val_r <= vote_bit_s;
                            end
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        phase_r <= PH_ZERO;
                        armed_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign RXD_S       = rxd_s_s;
    assign BUSY        = busy_r;
    assign START_DET   = start_det_r;
    assign FALSE_START = false_start_r;
    assign BIT_STB     = bit_stb_r;
    assign BIT_VAL     = bit_val_r;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_sampler
// Directed bench for uart_rx_sampler (OVERSAMPLE=16, BAUDTICK every 4 CLK).
// RXD for a tick is driven just after the previous tick, so the synchronized
// level is settled when the tick edge samples it.
// -----------------------------------------------------------------------------
module tb_uart_rx_sampler;

    logic CLK = 1'b0;
    logic RST, RXD, BAUDTICK, ENABLE, FRAME_END;
    logic RXD_S, BUSY, START_DET, FALSE_START, BIT_STB, BIT_VAL;

    int   n_checks  = 0;
    int   n_pass    = 0;
    int   tick_no   = 0;
    int   start_cnt = 0;
    int   false_cnt = 0;
    int   stb_cnt   = 0;
    logic stb_val  [0:31];
    int   stb_tick [0:31];
    int   det_tick;

    always #5 CLK = ~CLK;

    uart_rx_sampler dut (
        .CLK         (CLK),
        .RST         (RST),
        .RXD         (RXD),
        .BAUDTICK    (BAUDTICK),
        .ENABLE      (ENABLE),
        .FRAME_END   (FRAME_END),
        .RXD_S       (RXD_S),
        .BUSY        (BUSY),
        .START_DET   (START_DET),
        .FALSE_START (FALSE_START),
        .BIT_STB     (BIT_STB),
        .BIT_VAL     (BIT_VAL)
    );

    // Pulse monitor: counts every cycle each pulse output is high.
    always @(negedge CLK) begin
        if (START_DET === 1'b1) start_cnt <= start_cnt + 1;
        if (FALSE_START === 1'b1) false_cnt <= false_cnt + 1;
        if ((BIT_STB === 1'b1) && (stb_cnt < 32)) begin
            stb_val[stb_cnt]  <= BIT_VAL;
            stb_tick[stb_cnt] <= tick_no;
            stb_cnt           <= stb_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One baud tick period (4 CLK), RXD held at r; returns just after the
    // negedge following the tick edge, where registered pulses are visible.
    task automatic tick(input logic r);
        RXD      = r;
        BAUDTICK = 1'b0;
        repeat (3) @(negedge CLK);
        BAUDTICK = 1'b1;
        tick_no  = tick_no + 1;
        @(negedge CLK);
        #1;
        BAUDTICK = 1'b0;
    endtask

    // Line level for tick t of a frame: start bit, 0x55 LSB first, stop bit,
    // with a one-tick low glitch at the centre tick (P=8) of data bit 0.
    function automatic logic frame_bit(input int t);
        logic [7:0] data;
        int         k;
        data = 8'h55;
        if (t <= 16) return 1'b0;
        if (t == 25) return 1'b0;
        k = (t - 17) / 16;
        if (k < 8) return data[k];
        return 1'b1;
    endfunction

    initial begin
        logic [7:0] exp_data;
        logic       exp_bit;
        RST       = 1'b1;
        RXD       = 1'b1;
        BAUDTICK  = 1'b0;
        ENABLE    = 1'b1;
        FRAME_END = 1'b0;
        exp_data  = 8'h55;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        #1;

        // Reset state
        check_eq("rst_rxd_s", RXD_S, 1);
        check_eq("rst_busy", BUSY, 0);
        check_eq("rst_start_det", START_DET, 0);
        check_eq("rst_false_start", FALSE_START, 0);
        check_eq("rst_bit_stb", BIT_STB, 0);
        check_eq("rst_bit_val", BIT_VAL, 0);
        check_eq("rst_armed", dut.armed_r, 0);

        // One high tick arms the detector
        tick(1'b1);
        check_eq("arm_armed", dut.armed_r, 1);
        check_eq("arm_busy", BUSY, 0);

        // Full frame: start, 0x55, stop, with the glitch inside bit 0
        for (int t = 1; t <= 154; t++) begin
            tick(frame_bit(t));
            if (t == 1) begin
                det_tick = tick_no;
                check_eq("det_busy", BUSY, 1);
                check_eq("det_no_start_yet", START_DET, 0);
            end
            if (t == 9) check_eq("start_det_not_early", START_DET, 0);
            if (t == 10) check_eq("start_det_p9", START_DET, 1);
            if (t == 16) begin
                check_eq("start_cnt_one", start_cnt, 1);
                check_eq("no_false_start", false_cnt, 0);
                check_eq("data_busy", BUSY, 1);
            end
            if (t == 26) begin
                check_eq("glitch_stb", BIT_STB, 1);
                check_eq("glitch_bit0", BIT_VAL, 1);
            end
            if (t == 28) begin
                check_eq("stb_single", BIT_STB, 0);
                check_eq("bit_val_held", BIT_VAL, 1);
            end
        end
        check_eq("stop_stb", BIT_STB, 1);
        check_eq("stop_val", BIT_VAL, 1);
        FRAME_END = 1'b1;
        @(negedge CLK);
        #1;
        FRAME_END = 1'b0;
        check_eq("frame_end_busy", BUSY, 0);
        check_eq("frame_stb_cnt", stb_cnt, 9);
        for (int k = 0; k < 9; k++) begin
            exp_bit = (k < 8) ? exp_data[k] : 1'b1;
            check_eq($sformatf("frame_val%0d", k), stb_val[k], exp_bit);
            check_eq($sformatf("frame_tick%0d", k), stb_tick[k], det_tick + 25 + 16 * k);
        end

        // Break: line stays low after the frame, no new start
        for (int t = 0; t < 20; t++) tick(1'b0);
        check_eq("break_busy", BUSY, 0);
        check_eq("break_start_cnt", start_cnt, 1);
        check_eq("break_not_armed", dut.armed_r, 0);
        tick(1'b1);
        check_eq("break_rearm", dut.armed_r, 1);

        // False start: 3 low ticks then high
        tick(1'b0);
        check_eq("fs_busy", BUSY, 1);
        tick(1'b0);
        tick(1'b0);
        for (int t = 4; t <= 10; t++) begin
            tick(1'b1);
            if (t == 9) check_eq("fs_not_early", FALSE_START, 0);
        end
        check_eq("fs_pulse", FALSE_START, 1);
        check_eq("fs_busy_after", BUSY, 0);
        check_eq("fs_no_start_det", start_cnt, 1);
        tick(1'b1);
        check_eq("fs_single", false_cnt, 1);

        // ENABLE dropped mid-DATA
        for (int t = 1; t <= 30; t++) tick(frame_bit(t));
        check_eq("en_start_cnt", start_cnt, 2);
        check_eq("en_first_stb", stb_cnt, 10);
        check_eq("en_busy_before", BUSY, 1);
        ENABLE = 1'b0;
        @(negedge CLK);
        #1;
        check_eq("en_busy_off", BUSY, 0);
        for (int t = 31; t <= 70; t++) tick(frame_bit(t));
        check_eq("en_no_more_stb", stb_cnt, 10);
        check_eq("en_busy_idle", BUSY, 0);
        ENABLE = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
